puf_vote_reader: RTL and testbench
==================================

Name: puf_vote_reader

Overview:
- Read-path controller for the latch-PUF cell array; supersedes the single-shot registered word read.
- Re-excites the array NUM_SAMPLES times per request and captures the addressed OUT_BITS word after each settle.
- Outputs a per-bit majority vote plus a per-bit instability mask.
- Sits between the one_bit_puf array (instantiated in the top wrapper, flattened onto cell_bits) and the host; results are returned with a valid/ready handshake.

Parameters:
- ADDR_BITS, 4, word-address width; the array holds 2**ADDR_BITS words.
- OUT_BITS, 8, bits per word.
- NUM_SAMPLES, 5, excitations per request; legal range 1..15, odd recommended.
- SETTLE_CYCLES, 4, cycles cell_start is held high before each capture; minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  read request; accepted only when busy=0 and valid=0.
- addr  input  ADDR_BITS  word address; latched on acceptance.
- busy  output  1  high from acceptance until the result is handed off.
- valid  output  1  result available.
- ready  input  1  host accepts the result.
- data  output  OUT_BITS  majority-voted word.
- unstable  output  OUT_BITS  bit i is 1 if the samples for bit i disagreed.
- unstable_cnt  output  clog2(OUT_BITS+1)  popcount of unstable.
- cell_start  output  1  START drive to every PUF cell.
- cell_bits  input  2**ADDR_BITS*OUT_BITS  raw cell outputs; word a occupies bits [a*OUT_BITS +: OUT_BITS].

Behaviour:
- Reset (async):
  - State=IDLE; busy, valid, cell_start=0.
  - data, unstable, unstable_cnt=0.
  - Latched address, sample index and all per-bit one-counters cleared.
- All outputs are registered.
- IDLE:
  - cell_start=1 from the first clock after reset.
  - req=1 at a rising edge: latch addr, clear counters and sample index, busy<=1, go to ARM.
- ARM:
  - 1 cycle; cell_start=0 (re-excite); go to SETTLE.
- SETTLE:
  - cell_start=1 for exactly SETTLE_CYCLES cycles; go to SAMPLE.
- SAMPLE:
  - 1 cycle; cell_start=1.
  - At the closing edge, for each bit i: cnt[i] += cell_bits[laddr*OUT_BITS+i].
  - If sample_idx==NUM_SAMPLES-1, go to DONE. Otherwise increment sample_idx and go to ARM.
- Counters are clog2(NUM_SAMPLES+1) bits wide and never overflow.
- On entry to DONE, data/unstable/unstable_cnt are registered from the final counts:
  - data[i] = (2*cnt[i] > NUM_SAMPLES). An even-N tie resolves to 0.
  - unstable[i] = (cnt[i]!=0 && cnt[i]!=NUM_SAMPLES).
  - valid<=1.
- Latency: valid rises exactly NUM_SAMPLES*(SETTLE_CYCLES+2) rising edges after the accepting edge. Defaults give 30.
- DONE:
  - valid, data, unstable, unstable_cnt are held stable while ready=0.
  - On a valid&&ready edge: valid<=0, busy<=0, go to IDLE. data/unstable keep their last values.
  - A new req is not accepted on that same edge; earliest acceptance is the next edge.
- req while busy=1 or valid=1 is ignored; no queuing.
- addr changes after acceptance have no effect.
- ready while valid=0 is ignored.
- cell_bits is sampled only at the SAMPLE closing edge; changes at any other time have no effect.
- Reset mid-operation: immediate return to reset values. Any in-flight result is discarded and valid drops asynchronously.
- NUM_SAMPLES=1: data equals the single capture and unstable is always 0.

Test Plan:
- Constant word: cell_bits word 3 = 8'hA5 held, req addr=3 -> valid 30 cycles after acceptance, data=8'hA5, unstable=0, unstable_cnt=0; cell_start low exactly 5 single cycles.
- Majority vote: word 0 bit0 sampled 1,1,0,1,0 and bit7 sampled 0,0,0,1,0, rest 0 -> data=8'h01, unstable=8'h81, unstable_cnt=2.
- Top address: addr=4'hF, word 15 = 8'h3C, all other words 8'h00 -> data=8'h3C; confirms slice [120 +: 8].
- Backpressure: ready=0 for 10 cycles after valid -> outputs and valid held; ready=1 -> valid=0, busy=0 next edge; req on that edge ignored, accepted the following edge.
- Ignored request: req with addr=5 pulsed during SETTLE of an addr=2 read -> result reflects word 2 only; no second valid.
- Reset mid-op: reset asserted during the third SAMPLE -> busy, valid, cell_start, data=0 immediately; a fresh req after release gives correct data with full 30-cycle latency.

Source files
------------

// File: rtl/puf_vote_reader.sv
// ----------------------------------------------------------------------------
// puf_vote_reader
//
// Read-path controller for the latch-PUF cell array. A host request names a
// word address. The controller pulses the shared START line low to re-excite
// every cell, lets the cells settle, and captures the addressed word. It does
// this NUM_SAMPLES times, keeping a per-bit count of ones. From the final
// counts it returns a majority-voted word, a per-bit instability mask (bits
// whose samples disagreed) and the popcount of that mask. The result is handed
// to the host with a valid/ready handshake.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   req           read request, taken only while busy=0 and valid=0
//   addr          word address, latched when the request is taken
//   busy          high from acceptance until the result is handed off
//   valid         result available on data/unstable/unstable_cnt
//   ready         host takes the result when valid is high
//   data          majority-voted word
//   unstable      bit i set when the samples for bit i disagreed
//   unstable_cnt  number of set bits in unstable
//   cell_start    START drive to every PUF cell (low for one cycle re-excites)
//   cell_bits     flattened cell outputs, word a at [a*OUT_BITS +: OUT_BITS]
// ----------------------------------------------------------------------------
module puf_vote_reader #(
   parameter int ADDR_BITS     = 4,
   parameter int OUT_BITS      = 8,
   parameter int NUM_SAMPLES   = 5,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                req,
   input  logic [ADDR_BITS-1:0]                addr,
   output logic                                busy,
   output logic                                valid,
   input  logic                                ready,
   output logic [OUT_BITS-1:0]                 data,
   output logic [OUT_BITS-1:0]                 unstable,
   output logic [$clog2(OUT_BITS+1)-1:0]       unstable_cnt,
   output logic                                cell_start,
   input  logic [(2**ADDR_BITS)*OUT_BITS-1:0]  cell_bits
);

   // Counter widths. The sample index and the one-counters both have to
   // reach NUM_SAMPLES, so they share a width that can never overflow; using
   // NUM_SAMPLES+1 also keeps the width non-zero when NUM_SAMPLES is 1.
   localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int UC_W  = $clog2(OUT_BITS + 1);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SETTLE,
      SAMPLE,
      DONE
   } stateType;

   stateType             state, nextState;
   logic [ADDR_BITS-1:0] lAddr, nextLAddr;
   logic [CNT_W-1:0]     sampleIdx, nextSampleIdx;
   logic [SET_W-1:0]     settleCnt, nextSettleCnt;
   logic [CNT_W-1:0]     oneCnt     [OUT_BITS];
   logic [CNT_W-1:0]     nextOneCnt [OUT_BITS];
   logic [CNT_W-1:0]     cntPlus    [OUT_BITS];
   logic                 nextBusy, nextValid, nextCellStart;
   logic [OUT_BITS-1:0]  nextData, nextUnstable;
   logic [UC_W-1:0]      nextUnstableCnt;
   logic [OUT_BITS-1:0]  sampledWord;
   logic [OUT_BITS-1:0]  voteData, voteUnstable;
   logic [UC_W-1:0]      votePop;

   // The addressed word as the cells present it right now. Only the SAMPLE
   // state ever folds it into the counters.
   assign sampledWord = cell_bits[int'(lAddr)*OUT_BITS +: OUT_BITS];

   // Counts including the capture about to happen, and the vote derived from
   // them. The vote is taken from these rather than the stored counts so the
   // final sample is included in the result registered on entry to DONE.
   // A strict "more than half" test makes an even-N tie resolve to 0.
   always_comb begin
      voteData     = '0;
      voteUnstable = '0;
      votePop      = '0;
      for (int i = 0; i < OUT_BITS; i++) begin
         cntPlus[i]      = oneCnt[i] + CNT_W'(sampledWord[i]);
         voteData[i]     = (2 * int'(cntPlus[i])) > NUM_SAMPLES;
         voteUnstable[i] = (cntPlus[i] != '0) &&
                           (cntPlus[i] != CNT_W'(NUM_SAMPLES));
         votePop         = votePop + UC_W'(voteUnstable[i]);
      end
   end

   // Next-state and next-output logic. Every output is registered, so this
   // block computes the value each register takes at the coming edge.
   // cell_start follows the state being entered: low only while in ARM, which
   // is what produces the single-cycle re-excite pulse per sample.
   always_comb begin
      nextState       = state;
      nextLAddr       = lAddr;
      nextSampleIdx   = sampleIdx;
      nextSettleCnt   = settleCnt;
      nextOneCnt      = oneCnt;
      nextBusy        = busy;
      nextValid       = valid;
      nextData        = data;
      nextUnstable    = unstable;
      nextUnstableCnt = unstable_cnt;

      case (state)
         IDLE: begin
            if (req) begin
               nextLAddr     = addr;
               nextSampleIdx = '0;
               for (int i = 0; i < OUT_BITS; i++) begin
                  nextOneCnt[i] = '0;
               end
               nextBusy  = 1'b1;
               nextState = ARM;
            end
         end
         ARM: begin
            nextSettleCnt = '0;
            nextState     = SETTLE;
         end
         SETTLE: begin
            if (settleCnt == SET_W'(SETTLE_CYCLES - 1)) begin
               nextState = SAMPLE;
            end else begin
               nextSettleCnt = settleCnt + SET_W'(1);
            end
         end
         SAMPLE: begin
            nextOneCnt = cntPlus;
            if (sampleIdx == CNT_W'(NUM_SAMPLES - 1)) begin
               nextData        = voteData;
               nextUnstable    = voteUnstable;
               nextUnstableCnt = votePop;
               nextValid       = 1'b1;
               nextState       = DONE;
            end else begin
               nextSampleIdx = sampleIdx + CNT_W'(1);
               nextState     = ARM;
            end
         end
         DONE: begin
            // Going back through IDLE means a request cannot be taken on the
            // handoff edge itself; the earliest acceptance is the edge after.
            if (ready) begin
               nextValid = 1'b0;
               nextBusy  = 1'b0;
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase

      nextCellStart = (nextState != ARM);
   end

   // State and output registers. Reset clears everything at once, so an
   // in-flight result is dropped and valid falls without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         lAddr        <= '0;
         sampleIdx    <= '0;
         settleCnt    <= '0;
         for (int i = 0; i < OUT_BITS; i++) begin
            oneCnt[i] <= '0;
         end
         busy         <= 1'b0;
         valid        <= 1'b0;
         data         <= '0;
         unstable     <= '0;
         unstable_cnt <= '0;
         cell_start   <= 1'b0;
      end else begin
         state        <= nextState;
         lAddr        <= nextLAddr;
         sampleIdx    <= nextSampleIdx;
         settleCnt    <= nextSettleCnt;
         oneCnt       <= nextOneCnt;
         busy         <= nextBusy;
         valid        <= nextValid;
         data         <= nextData;
         unstable     <= nextUnstable;
         unstable_cnt <= nextUnstableCnt;
         cell_start   <= nextCellStart;
      end
   end

endmodule

// File: tb/tb_puf_vote_reader.sv
// ----------------------------------------------------------------------------
// tb_puf_vote_reader
//
// Scoreboard bench for puf_vote_reader. The driver chooses the word the
// addressed cells show at every capture, computes the expected vote by
// counting ones per bit, and queues it when the request is taken. A separate
// monitor compares whatever the DUT presents on valid against the head of the
// queue, including latency and the number of re-excite pulses.
// ----------------------------------------------------------------------------
module tb_puf_vote_reader;

   localparam int ADDR_BITS     = 4;
   localparam int OUT_BITS      = 8;
   localparam int NUM_SAMPLES   = 5;
   localparam int SETTLE_CYCLES = 4;
   localparam int WINDOW        = SETTLE_CYCLES + 2;
   localparam int LATENCY       = NUM_SAMPLES * WINDOW;
   localparam int NUM_WORDS     = 1 << ADDR_BITS;

   logic                              clk = 1'b0;
   logic                              reset;
   logic                              req;
   logic [ADDR_BITS-1:0]              addr;
   logic                              busy;
   logic                              valid;
   logic                              ready;
   logic [OUT_BITS-1:0]               data;
   logic [OUT_BITS-1:0]               unstable;
   logic [$clog2(OUT_BITS+1)-1:0]     unstable_cnt;
   logic                              cell_start;
   logic [NUM_WORDS*OUT_BITS-1:0]     cell_bits;

   typedef struct {
      logic [OUT_BITS-1:0] data;
      logic [OUT_BITS-1:0] unst;
      logic [3:0]          ucnt;
      int                  acceptCycle;
   } expType;

   expType              scoreboard[$];
   logic [OUT_BITS-1:0] pattern [NUM_SAMPLES];
   int                  assertCount = 0;
   int                  failCount   = 0;
   int                  cycle       = 0;
   int                  lastAcceptWait = 0;
   int                  lowCount    = 0;
   logic                prevValid   = 1'b0;
   expType              monHead;

   puf_vote_reader #(
      .ADDR_BITS(ADDR_BITS),
      .OUT_BITS(OUT_BITS),
      .NUM_SAMPLES(NUM_SAMPLES),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .addr(addr),
      .busy(busy),
      .valid(valid),
      .ready(ready),
      .data(data),
      .unstable(unstable),
      .unstable_cnt(unstable_cnt),
      .cell_start(cell_start),
      .cell_bits(cell_bits)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                  name, actual, expected, $time);
      end
   endtask

   // Reference vote: count ones per bit over the chosen captures.
   function automatic expType modelResult();
      expType r;
      int     ones;
      r.data = '0;
      r.unst = '0;
      for (int i = 0; i < OUT_BITS; i++) begin
         ones = 0;
         for (int k = 0; k < NUM_SAMPLES; k++) ones += int'(pattern[k][i]);
         r.data[i] = (ones * 2 > NUM_SAMPLES);
         r.unst[i] = (ones > 0) && (ones < NUM_SAMPLES);
      end
      r.ucnt = 4'($countones(r.unst));
      r.acceptCycle = 0;
      return r;
   endfunction

   function automatic logic [NUM_WORDS*OUT_BITS-1:0] randomArray();
      logic [NUM_WORDS*OUT_BITS-1:0] v;
      for (int w = 0; w < NUM_WORDS; w++) v[w*OUT_BITS +: OUT_BITS] = OUT_BITS'($urandom);
      return v;
   endfunction

   // One read. With noise the whole array (including the addressed word
   // between captures) carries garbage; only the capture cycle shows the
   // chosen pattern. Stray req/addr/ready toggles are thrown in while busy.
   // abortSample >= 0 asserts reset during that sample's capture cycle.
   task automatic applyStimulus(input logic [ADDR_BITS-1:0] a, input bit noise,
                                input int bp, input bit reqOnHandshake,
                                input logic [ADDR_BITS-1:0] nextAddr,
                                input int abortSample);
      expType e;
      int     waited;
      addr   = a;
      req    = 1'b1;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!busy && waited < 20);
      lastAcceptWait = waited;
      checkOutput("accept", 32'(busy), 32'd1);
      if (!busy) begin
         req = 1'b0;
         return;
      end
      e = modelResult();
      e.acceptCycle = cycle;
      scoreboard.push_back(e);
      req = 1'b0;

      for (int k = 0; k < NUM_SAMPLES; k++) begin
         for (int c = 1; c <= WINDOW; c++) begin
            if (k == abortSample && c == WINDOW) begin
               reset = 1'b1;
               req   = 1'b0;
               ready = 1'b0;
               #1;
               checkOutput("reset busy", 32'(busy), 32'd0);
               checkOutput("reset valid", 32'(valid), 32'd0);
               checkOutput("reset cell_start", 32'(cell_start), 32'd0);
               checkOutput("reset data", 32'(data), 32'd0);
               scoreboard.delete();
               @(negedge clk);
               reset = 1'b0;
               return;
            end
            cell_bits = noise ? randomArray() : '0;
            if (c == WINDOW || !noise) cell_bits[int'(a)*OUT_BITS +: OUT_BITS] = pattern[k];
            if (c >= 2 && c < WINDOW && $urandom_range(0, 1) == 1) begin
               req  = 1'b1;
               addr = ADDR_BITS'($urandom);
            end else begin
               req = 1'b0;
            end
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
      end
      req   = 1'b0;
      ready = 1'b0;
      addr  = nextAddr;

      waited = 0;
      while (!valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("valid arrives", 32'(valid), 32'd1);
      if (!valid) begin
         scoreboard.delete();
         return;
      end
      repeat (bp) begin
         req = reqOnHandshake;
         cell_bits = randomArray();
         @(negedge clk);
      end
      ready = 1'b1;
      req   = reqOnHandshake;
      @(negedge clk);
      ready = 1'b0;
      #1;
      checkOutput("handshake valid drop", 32'(valid), 32'd0);
      checkOutput("handshake busy drop", 32'(busy), 32'd0);
   endtask

   // Monitor: samples 2 time units after the falling edge, well clear of the
   // rising edge and after the driver has settled its inputs.
   always @(negedge clk) begin
      #2;
      if (reset || !busy) lowCount = 0;
      else if (!valid && !cell_start) lowCount++;
      if (valid) begin
         if (scoreboard.size() == 0) begin
            checkOutput("unexpected valid", 32'(valid), 32'd0);
         end else begin
            monHead = scoreboard[0];
            if (!prevValid) begin
               checkOutput("latency", 32'(cycle - monHead.acceptCycle), 32'(LATENCY));
               checkOutput("cell_start low cycles", 32'(lowCount), 32'(NUM_SAMPLES));
            end
            checkOutput("data", 32'(data), 32'(monHead.data));
            checkOutput("unstable", 32'(unstable), 32'(monHead.unst));
            checkOutput("unstable_cnt", 32'(unstable_cnt), 32'(monHead.ucnt));
            checkOutput("busy with valid", 32'(busy), 32'd1);
            if (ready) void'(scoreboard.pop_front());
         end
      end
      prevValid = valid;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset     = 1'b1;
      req       = 1'b0;
      addr      = '0;
      ready     = 1'b0;
      cell_bits = '0;
      #1;
      checkOutput("init busy", 32'(busy), 32'd0);
      checkOutput("init valid", 32'(valid), 32'd0);
      checkOutput("init cell_start", 32'(cell_start), 32'd0);
      checkOutput("init data", 32'(data), 32'd0);
      checkOutput("init unstable", 32'(unstable), 32'd0);
      checkOutput("init unstable_cnt", 32'(unstable_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("idle cell_start", 32'(cell_start), 32'd1);

      // Constant word at address 3.
      for (int k = 0; k < NUM_SAMPLES; k++) pattern[k] = 8'hA5;
      applyStimulus(4'd3, 1'b1, 0, 1'b0, '0, -1);

      // Majority vote on word 0: bit0 1,1,0,1,0 and bit7 0,0,0,1,0.
      pattern = '{8'h01, 8'h01, 8'h00, 8'h81, 8'h00};
      applyStimulus(4'd0, 1'b1, 0, 1'b0, '0, -1);

      // Top address, everything else zero.
      for (int k = 0; k < NUM_SAMPLES; k++) pattern[k] = 8'h3C;
      applyStimulus(4'hF, 1'b0, 0, 1'b0, '0, -1);

      // Backpressure with a request held through the handoff edge.
      for (int k = 0; k < NUM_SAMPLES; k++) pattern[k] = OUT_BITS'($urandom);
      applyStimulus(4'd6, 1'b1, 10, 1'b1, 4'd9, -1);
      for (int k = 0; k < NUM_SAMPLES; k++) pattern[k] = OUT_BITS'($urandom);
      applyStimulus(4'd9, 1'b1, 0, 1'b0, '0, -1);
      checkOutput("accept after handshake", 32'(lastAcceptWait), 32'd1);

      // Read of word 2 with stray requests while busy; no second operation.
      for (int k = 0; k < NUM_SAMPLES; k++) pattern[k] = OUT_BITS'($urandom);
      applyStimulus(4'd2, 1'b1, 0, 1'b0, '0, -1);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("idle after read", 32'(busy), 32'd0);

      // Reset during the third capture, then a fresh full read.
      for (int k = 0; k < NUM_SAMPLES; k++) pattern[k] = OUT_BITS'($urandom);
      applyStimulus(4'd7, 1'b1, 0, 1'b0, '0, 2);
      for (int k = 0; k < NUM_SAMPLES; k++) pattern[k] = OUT_BITS'($urandom);
      applyStimulus(4'd7, 1'b1, 0, 1'b0, '0, -1);

      // Randomized reads.
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < NUM_SAMPLES; k++) pattern[k] = OUT_BITS'($urandom);
         applyStimulus(ADDR_BITS'($urandom), 1'b1, int'($urandom_range(0, 3)),
                       1'b0, '0, -1);
      end

      repeat (40) @(negedge clk);
      checkOutput("scoreboard drained", 32'(scoreboard.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
